instr_packer: RTL

Write-side counterpart of the fetch alignment stage. Accepts a stream of instructions, either full 32-bit or already-compressed 16-bit, and packs them at halfword granularity into 32-bit memory words. Each word carries a target address. The output is the exact image the fetch alignment/decompress path consumes: halfwords byte-swapped, a 32-bit instruction low half first, and a zero halfword never used as a compressed instruction. It sits between the program loader/compressor and the instruction-memory write port.

---
 rtl/instr_packer_pkg.sv | 8 +
 rtl/instr_packer_if.sv | 23 ++
 rtl/instr_packer_out_stage.sv | 32 +++
 rtl/instr_packer.sv | 70 +++++++
 4 files changed

// File: rtl/instr_packer_pkg.sv
// instr_packer_pkg: shared constants, FSM state type and halfword swap helper.
package instr_packer_pkg;
    localparam logic [15:0] CNOP_HW = 16'h0001;
    typedef enum logic [1:0] {EMPTY, HALF, FLUSH} pack_state_e;
    function automatic logic [15:0] hw_swap(input logic [15:0] h);
        return {h[7:0], h[15:8]};
    endfunction
endpackage

// File: rtl/instr_packer_if.sv
// instr_packer_if: instruction-in / word-out bus of the packer.
// master = loader + memory side, slave = packer side.
interface instr_packer_if #(parameter int ADDR_W = 32);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              in_is_compress;
    logic              flush;
    logic              flush_busy;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    modport master (
        output in_valid, in_instr, in_is_compress, flush, out_ready,
        input  in_ready, flush_busy, out_valid, out_word, out_addr, err
    );
    modport slave (
        input  in_valid, in_instr, in_is_compress, flush, out_ready,
        output in_ready, flush_busy, out_valid, out_word, out_addr, err
    );
endinterface

// File: rtl/instr_packer_out_stage.sv
// instr_packer_out_stage: valid/ready output word register with address counter.
// load/load_word: new word (caller only loads when the slot is free);
// out_valid/out_ready/out_word/out_addr: memory write side.
module instr_packer_out_stage #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [31:0]       load_word,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr
);
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            out_addr  <= BASE_ADDR;
        end else begin
            if (out_valid && out_ready) out_addr <= out_addr + ADDR_W'(4);
            if (load) begin
                out_valid <= 1'b1;
                out_word  <= load_word;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/instr_packer.sv
// instr_packer: packs 32-bit and 16-bit compressed instructions into byte-swapped 32-bit memory words.
// clk/rst: clock, sync active-high reset; bus: instruction input, flush request,
// packed word output with address, sticky illegal-compressed err.
module instr_packer
    import instr_packer_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic           clk,
    input  logic           rst,
    instr_packer_if.slave  bus
);
    pack_state_e state;
    logic [15:0] pend_hw, lo, hi;
    logic        err_q, busy_q, slot_free, acc, illegal, emit;
    logic [31:0] emit_word;

    assign lo        = bus.in_instr[15:0];
    assign hi        = bus.in_instr[31:16];
    assign slot_free = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !rst && state != FLUSH && !bus.flush && slot_free;
    assign acc       = bus.in_valid && bus.in_ready;
    assign illegal   = bus.in_is_compress && (lo[1:0] == 2'b11 || lo == 16'h0);
    // Only EMPTY + compressed is a non-emitting accept; the pad word goes out once the slot frees.
    assign emit      = (acc && !illegal && (state == HALF || !bus.in_is_compress)) ||
                       (state == FLUSH && slot_free);
    assign emit_word = state == EMPTY ? {hw_swap(lo), hw_swap(hi)} :
                       {hw_swap(pend_hw), state == FLUSH ? hw_swap(CNOP_HW) : hw_swap(lo)};
    assign bus.err        = err_q;
    assign bus.flush_busy = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            pend_hw <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (acc && illegal) err_q <= 1'b1;
            if (acc && !illegal) begin
                if (state == EMPTY && bus.in_is_compress) begin
                    pend_hw <= lo;
                    state   <= HALF;
                end else if (state == HALF) begin
                    if (bus.in_is_compress) state <= EMPTY;
                    else pend_hw <= hi;
                end
            end else if (bus.flush && state == HALF) begin
                state  <= FLUSH;
                busy_q <= 1'b1;
            end else if (state == FLUSH && slot_free) begin
                state <= EMPTY;
            end
            // Once the pad word sits in the output register, its handshake ends the flush.
            if (busy_q && state != FLUSH && bus.out_valid && bus.out_ready) busy_q <= 1'b0;
        end
    end

    instr_packer_out_stage #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (emit),
        .load_word (emit_word),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_word  (bus.out_word),
        .out_addr  (bus.out_addr)
    );
endmodule
